// File: rtl/modulation_pkg.sv
// rtl/modulation_pkg.sv - shared types and constants for the modulation sequencer
package modulation_pkg;

   // Sequencer state; encoding is also used by any status readout
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   localparam int ANGLE_W    = 12;
   localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/modulation_sequencer_if.sv
// rtl/modulation_sequencer_if.sv - configuration handshake bundle (period/step offer)
interface modulation_sequencer_if #(
   parameter int PERIOD_W = 16,
   parameter int ACC_W    = 24
);
   logic                cfg_valid;
   logic                cfg_ready;
   logic [PERIOD_W-1:0] cfg_period;
   logic [ACC_W-1:0]    cfg_step;

   modport master (output cfg_valid, output cfg_period, output cfg_step, input cfg_ready);
   modport slave  (input cfg_valid, input cfg_period, input cfg_step, output cfg_ready);
endinterface

// File: rtl/modulation_sequencer_period_timer.sv
// rtl/modulation_sequencer_period_timer.sv - loadable down-counter flagging zero
module period_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         enable,
   input  logic [W-1:0] load_value,
   output logic         tick
);
   logic [W-1:0] count;

   // Load wins over counting; the counter parks at zero until reloaded
   always_ff @(posedge clk) begin
      if (!reset)
         count <= '0;
      else if (load)
         count <= load_value;
      else if (enable && count != '0)
         count <= count - W'(1);
   end

   assign tick = (count == '0);
endmodule

// File: rtl/modulation_sequencer.sv
// rtl/modulation_sequencer.sv - phase accumulator and shoot strobe generator for the modulator
module modulation_sequencer
   import modulation_pkg::*;
#(
   parameter int PERIOD_W       = 16,
   parameter int ACC_W          = 24,
   parameter int DEFAULT_PERIOD = 1000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               stop,
   input  logic               fault,
   input  logic               fault_clr,
   modulation_sequencer_if.slave cfg,
   output logic [ANGLE_W-1:0] angle,
   output logic               shoot,
   output logic               running,
   output logic               halted
);
   state_t              state, state_next;
   logic [ACC_W-1:0]    acc, acc_base, step_q, step_eff, shadow_step;
   logic [PERIOD_W-1:0] period_q, period_eff, shadow_period, period_clamped;
   logic                shadow_full, ready_q;
   logic                fire, apply, transfer, tick;

   // Entering RUN shoots on the same edge, so the first strobe lands right after start
   always_comb begin
      state_next = state;
      fire       = 1'b0;
      case (state)
         ST_IDLE: if (start && !stop) begin
            state_next = ST_RUN;
            fire       = 1'b1;
         end
         ST_RUN: begin
            if (stop) state_next = ST_IDLE;
            else      fire       = tick;
         end
         ST_HALT: if (fault_clr) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
      if (fault) begin
         state_next = ST_HALT;
         fire       = 1'b0;
      end
   end

   assign transfer       = cfg.cfg_valid && ready_q;
   assign apply          = shadow_full && (state != ST_RUN || fire);
   assign period_eff     = apply ? shadow_period : period_q;
   assign step_eff       = apply ? shadow_step : step_q;
   assign acc_base       = (state == ST_RUN) ? acc : '0;
   assign period_clamped = (cfg.cfg_period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD)
                                                                     : cfg.cfg_period;
   assign cfg.cfg_ready  = ready_q;

   period_timer #(.W(PERIOD_W)) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (fire),
      .enable     (state == ST_RUN),
      .load_value (period_eff - PERIOD_W'(1)),
      .tick       (tick)
   );

   // State, registered outputs, accumulator and the config shadow register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= ST_IDLE;
         acc           <= '0;
         angle         <= '0;
         shoot         <= 1'b0;
         running       <= 1'b0;
         halted        <= 1'b0;
         period_q      <= PERIOD_W'(DEFAULT_PERIOD);
         step_q        <= '0;
         shadow_full   <= 1'b0;
         shadow_period <= '0;
         shadow_step   <= '0;
         ready_q       <= 1'b1;
      end else begin
         state   <= state_next;
         shoot   <= fire;
         running <= (state_next == ST_RUN);
         halted  <= (state_next == ST_HALT);
         if (fire) begin
            angle <= acc_base[ACC_W-1 -: ANGLE_W];
            acc   <= acc_base + step_eff;
         end
         if (apply) begin
            period_q    <= shadow_period;
            step_q      <= shadow_step;
            shadow_full <= 1'b0;
            ready_q     <= 1'b1;
         end else if (transfer) begin
            shadow_period <= period_clamped;
            shadow_step   <= cfg.cfg_step;
            shadow_full   <= 1'b1;
            ready_q       <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_modulation_sequencer.sv
// tb/tb_modulation_sequencer.sv - self-checking bench for modulation_sequencer
module tb_modulation_sequencer;
   logic        clk = 1'b0;
   logic        rst_n, start, stop, fault, fault_clr;
   logic [11:0] angle;
   logic        shoot, running, halted;

   modulation_sequencer_if #(.PERIOD_W(16), .ACC_W(24)) cfg_bus ();

   modulation_sequencer #(.PERIOD_W(16), .ACC_W(24), .DEFAULT_PERIOD(1000)) dut (
      .clk       (clk),
      .reset     (rst_n),
      .start     (start),
      .stop      (stop),
      .fault     (fault),
      .fault_clr (fault_clr),
      .cfg       (cfg_bus.slave),
      .angle     (angle),
      .shoot     (shoot),
      .running   (running),
      .halted    (halted)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   int n_shoot = 0;

   // Reference model: mode 0 idle, 1 run, 2 halt; shoots scheduled by absolute cycle number
   int              cyc = 0;
   int              m_mode = 0;
   int              m_next = 0;
   int              m_per = 1000;
   longint unsigned m_acc = 0;
   longint unsigned m_step = 0;
   bit              m_pend = 0;
   int              m_pper = 0;
   longint unsigned m_pstep = 0;
   bit              e_shoot = 0;
   bit              e_ready = 1;
   int              e_angle = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic model_edge();
      bit fire;
      int nxt;
      cyc++;
      if (!rst_n) begin
         m_mode = 0; m_acc = 0; m_per = 1000; m_step = 0; m_pend = 0;
         e_shoot = 0; e_ready = 1; e_angle = 0;
      end else begin
         fire = 0;
         nxt  = m_mode;
         if (fault) nxt = 2;
         else if (m_mode == 0) begin
            if (start && !stop) begin nxt = 1; fire = 1; end
         end else if (m_mode == 1) begin
            if (stop) nxt = 0;
            else if (cyc == m_next) fire = 1;
         end else if (fault_clr) nxt = 0;
         if (m_pend && (m_mode != 1 || fire)) begin
            m_per  = m_pper;
            m_step = m_pstep;
            m_pend = 0;
         end else if (cfg_bus.cfg_valid && e_ready) begin
            m_pend  = 1;
            m_pper  = (cfg_bus.cfg_period < 2) ? 2 : int'(cfg_bus.cfg_period);
            m_pstep = longint'(cfg_bus.cfg_step);
         end
         if (fire) begin
            if (m_mode == 0) m_acc = 0;
            e_angle = int'((m_acc >> 12) & 64'hFFF);
            m_acc   = (m_acc + m_step) & 64'hFFFFFF;
            m_next  = cyc + m_per;
         end
         e_shoot = fire;
         m_mode  = nxt;
         e_ready = !m_pend;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      if (shoot) n_shoot++;
      check("shoot", 32'(shoot), 32'(e_shoot));
      check("angle", 32'(angle), 32'(e_angle));
      check("running", 32'(running), 32'(m_mode == 1));
      check("halted", 32'(halted), 32'(m_mode == 2));
      check("cfg_ready", 32'(cfg_bus.cfg_ready), 32'(e_ready));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      bit found;
      rst_n = 0; start = 0; stop = 0; fault = 0; fault_clr = 0;
      cfg_bus.cfg_valid = 0; cfg_bus.cfg_period = '0; cfg_bus.cfg_step = '0;
      run(3);
      rst_n = 1;

      // Period 10, step 1/16 turn: angles step by 0x100 and wrap after 16 shoots
      cfg_bus.cfg_valid = 1; cfg_bus.cfg_period = 16'd10; cfg_bus.cfg_step = 24'h100000;
      tick();
      cfg_bus.cfg_valid = 0;
      run(3);
      start = 1; tick(); start = 0;
      check("first_shoot_angle0", 32'(angle), 32'h0);
      run(170);

      // Shorter period offered mid-period takes effect at the next boundary
      run(3);
      cfg_bus.cfg_valid = 1; cfg_bus.cfg_period = 16'd4; cfg_bus.cfg_step = 24'h100000;
      tick();
      cfg_bus.cfg_valid = 0;
      run(30);

      // Fault on the exact cycle a shoot is due
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (m_mode == 1 && cyc + 1 == m_next) found = 1;
         else tick();
      end
      check("due_found", 32'(found), 32'h1);
      fault = 1; tick();
      check("fault_no_shoot", 32'(shoot), 32'h0);
      start = 1; tick(); start = 0;
      fault_clr = 1; tick(); fault_clr = 0;
      run(2);
      fault = 0; tick();
      fault_clr = 1; tick(); fault_clr = 0;
      check("cleared_halted", 32'(halted), 32'h0);
      run(2);

      // start+stop together in IDLE, then stop in RUN
      start = 1; stop = 1; tick(); start = 0; stop = 0;
      run(3);
      start = 1; tick(); start = 0;
      run(15);
      stop = 1; tick(); stop = 0;
      run(10);

      // Clamped period 0 -> spacing 2, step 0 -> constant angle
      cfg_bus.cfg_valid = 1; cfg_bus.cfg_period = 16'd0; cfg_bus.cfg_step = 24'h0;
      tick();
      cfg_bus.cfg_valid = 0;
      run(2);
      start = 1; n_shoot = 0; tick(); start = 0;
      run(19);
      check("clamp_spacing", 32'(n_shoot), 32'd10);

      // Reset mid-RUN, then default period after restart
      run(5);
      rst_n = 0; tick(); rst_n = 1;
      check("reset_angle", 32'(angle), 32'h0);
      start = 1; n_shoot = 0; tick(); start = 0;
      run(1004);
      check("default_period_shoots", 32'(n_shoot), 32'd2);
      stop = 1; tick(); stop = 0;

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         rst_n     = ($urandom_range(0, 199) != 0);
         start     = ($urandom_range(0, 9) == 0);
         stop      = ($urandom_range(0, 29) == 0);
         fault     = ($urandom_range(0, 39) == 0);
         fault_clr = ($urandom_range(0, 4) == 0);
         cfg_bus.cfg_valid  = ($urandom_range(0, 5) == 0);
         cfg_bus.cfg_period = 16'($urandom_range(0, 12));
         cfg_bus.cfg_step   = 24'($urandom);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
